uacc_window: RTL and testbench

Windowed-sum extractor placed directly downstream of the free-running unsigned multiply-accumulator. It samples the accumulator once every WINLEN enabled cycles and subtracts the previous sample modulo 2^IWIDTH, which recovers the sum of products over that window without clearing the accumulator. Each window sum is scaled, saturated and queued in a 2-entry output FIFO behind a valid/ready handshake.

---
 rtl/uacc_pkg.sv | 12 +
 rtl/uacc_fifo2.sv | 54 +++++
 rtl/uacc_window.sv | 121 ++++++++++++
 tb/tb_uacc_window.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uacc_pkg.sv
// Shared constants and default result layout for the uacc window extractor.
package uacc_pkg;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned RES_DW     = 16;

    typedef struct packed {
        logic              sat;
        logic [RES_DW-1:0] data;
    } uacc_res_t;

endpackage

// File: rtl/uacc_fifo2.sv
// Two-entry first-word-fall-through FIFO; a push on a full FIFO is accepted
// only when a pop happens in the same cycle.
module uacc_fifo2
    import uacc_pkg::*;
#(
    parameter int unsigned DW = $bits(uacc_res_t)
) (
    input  logic          clk,
    input  logic          aclr_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic          rptr_q, rptr_d;
    logic          wptr_q, wptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == 2'd0);
    assign full    = (cnt_q == 2'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q];

    always_comb begin
        rptr_d = rptr_q ^ do_pop;
        wptr_d = wptr_q ^ do_push;
        cnt_d  = cnt_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            rptr_q <= 1'b0;
            wptr_q <= 1'b0;
            cnt_q  <= 2'd0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
            end
        end
    end

endmodule

// File: rtl/uacc_window.sv
// Windowed-sum extractor: samples a free-running accumulator every WINLEN
// enabled cycles; UACC_WINDOW_ROUND_EN selects round-half-up scaling.
module uacc_window
    import uacc_pkg::*;
#(
    parameter int unsigned IWIDTH = 17,
    parameter int unsigned OWIDTH = 16,
    parameter int unsigned WINLEN = 16,
    parameter int unsigned SHIFT  = 0
) (
    input  logic              clk,
    input  logic              aclr_n,
    input  logic              clken,
    input  logic [IWIDTH-1:0] acc,
    input  logic              win_rst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OWIDTH-1:0] out_data,
    output logic              out_sat,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int unsigned    CW       = $clog2(WINLEN);
    localparam int unsigned    SW       = IWIDTH + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WINLEN - 1);
`ifdef UACC_WINDOW_ROUND_EN
    localparam logic [SW-1:0]  RND = (SHIFT > 0) ? (SW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
    localparam logic [SW-1:0]  RND = '0;
`endif

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IWIDTH-1:0] prev_q, prev_d;
    logic [IWIDTH-1:0] diff_q, diff_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q;
    logic [OWIDTH:0]   s2_q, s2_d;
    logic              ovf_q, ovf_d;

    logic [SW-1:0]     rounded, scaled;
    logic              sat;
    logic              fifo_full, fifo_empty, fifo_pop, drop;
    logic [OWIDTH:0]   fifo_rdata;

    // win_rst re-bases the window even on a terminal cycle, so no result leaves.
    always_comb begin
        cnt_d      = cnt_q;
        prev_d     = prev_q;
        diff_d     = diff_q;
        s1_valid_d = 1'b0;
        if (win_rst) begin
            cnt_d  = '0;
            prev_d = acc;
        end else if (clken) begin
            if (cnt_q == CNT_LAST) begin
                diff_d     = acc - prev_q;
                prev_d     = acc;
                cnt_d      = '0;
                s1_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign rounded = {1'b0, diff_q} + RND;
    assign scaled  = rounded >> SHIFT;
    assign sat     = |(scaled >> OWIDTH);
    assign s2_d    = {sat, sat ? {OWIDTH{1'b1}} : OWIDTH'(scaled)};

    assign fifo_pop = out_valid && out_ready;
    assign drop     = s2_valid_q && fifo_full && !fifo_pop;

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            cnt_q      <= '0;
            prev_q     <= '0;
            diff_q     <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            diff_q     <= diff_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s1_valid_q;
            s2_q       <= s2_d;
            ovf_q      <= ovf_d;
        end
    end

    uacc_fifo2 #(
        .DW (OWIDTH + 1)
    ) u_fifo (
        .clk    (clk),
        .aclr_n (aclr_n),
        .push   (s2_valid_q),
        .wdata  (s2_q),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign out_valid           = !fifo_empty;
    assign {out_sat, out_data} = fifo_rdata;
    assign ovf                 = ovf_q;

endmodule

// File: tb/tb_uacc_window.sv
// Randomized scoreboard bench for uacc_window against a queue-based reference model.
module tb_uacc_window;

    localparam int unsigned IW = 8;
    localparam int unsigned OW = 6;
    localparam int unsigned WL = 4;
    localparam int unsigned SH = 1;

    logic          clk = 1'b0;
    logic          aclr_n = 1'b0;
    logic          clken = 1'b0;
    logic          win_rst = 1'b0;
    logic          out_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [IW-1:0] acc = '0;
    logic          out_valid, out_sat, ovf;
    logic [OW-1:0] out_data;

    uacc_window #(
        .IWIDTH (IW),
        .OWIDTH (OW),
        .WINLEN (WL),
        .SHIFT  (SH)
    ) dut (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .clken     (clken),
        .acc       (acc),
        .win_rst   (win_rst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int data;
        int sat;
    } res_t;

    res_t pend_q[$];
    res_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int m_cnt = 0;
    int m_prev = 0;
    int m_occ = 0;
    int m_ovf = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Window sum from two accumulator samples, scaled and clipped to OW bits.
    function automatic res_t window_result(int a, int p);
        res_t r;
        int   diff, sc;
        diff = (a - p + (1 << IW)) % (1 << IW);
`ifdef UACC_WINDOW_ROUND_EN
        sc = (SH > 0) ? ((diff + (1 << (SH - 1))) >> SH) : diff;
`else
        sc = diff >> SH;
`endif
        r.due  = 0;
        r.sat  = (sc > (1 << OW) - 1) ? 1 : 0;
        r.data = (r.sat != 0) ? (1 << OW) - 1 : sc;
        return r;
    endfunction

    // Reference model: results become FIFO candidates two edges after sampling.
    res_t mr;
    int   dropped;
    initial forever begin
        @(posedge clk or negedge aclr_n);
        if (!aclr_n) begin
            m_cnt  = 0;
            m_prev = 0;
            m_occ  = 0;
            m_ovf  = 0;
            pend_q.delete();
            exp_q.delete();
        end else begin
            if (m_occ > 0 && out_ready) m_occ--;
            dropped = 0;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                if (m_occ < 2) begin
                    m_occ++;
                    exp_q.push_back(pend_q[0]);
                end else begin
                    dropped = 1;
                end
                void'(pend_q.pop_front());
            end
            if (dropped != 0) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            if (win_rst) begin
                m_cnt  = 0;
                m_prev = int'(acc);
            end else if (clken) begin
                m_cnt++;
                if (m_cnt == int'(WL)) begin
                    mr     = window_result(int'(acc), m_prev);
                    mr.due = cyc + 2;
                    pend_q.push_back(mr);
                    m_prev = int'(acc);
                    m_cnt  = 0;
                end
            end
            cyc++;
        end
    end

    // Monitor: per-cycle handshake/flag checks and scoreboard pops.
    res_t er;
    initial forever begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            chk("out_valid", int'(out_valid), (m_occ > 0) ? 1 : 0);
            chk("ovf", int'(ovf), m_ovf);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop actual=%0d expected=none (t=%0t)", out_data, $time);
                end else begin
                    er = exp_q.pop_front();
                    chk("out_data", int'(out_data), er.data);
                    chk("out_sat", int'(out_sat), er.sat);
                end
            end
        end
    end

    task automatic step(int inc_max, int clk_pct, int rdy_pct, int wr_pct, int clr_pct);
        @(negedge clk);
        acc       = acc + IW'($urandom_range(inc_max));
        clken     = ($urandom_range(99) < clk_pct);
        out_ready = ($urandom_range(99) < rdy_pct);
        win_rst   = ($urandom_range(99) < wr_pct);
        ovf_clr   = ($urandom_range(99) < clr_pct);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        chk("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        aclr_n = 1'b1;
        mon_en = 1'b1;

        // Small sums, free-flowing output.
        repeat (80) step(20, 80, 100, 3, 0);
        // Large steps: wrap, saturation, rounding, random backpressure.
        repeat (150) step(80, 90, 50, 3, 5);

        // Sustained backpressure across three or more windows.
        repeat (3 * WL + 6) step(30, 100, 0, 0, 0);
        repeat (4) step(30, 0, 0, 0, 0);
        #1;
        chk("ovf_after_stall", int'(ovf), 1);
        chk("fifo_held_two", exp_q.size(), 2);
        step(30, 0, 0, 0, 100);
        step(30, 0, 0, 0, 0);
        #1;
        chk("ovf_cleared", int'(ovf), 0);
        repeat (6) step(30, 0, 100, 0, 0);
        #1;
        chk("drained", exp_q.size(), 0);

        // win_rst landing exactly on terminal cycles.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            acc       = acc + IW'($urandom_range(40));
            clken     = 1'b1;
            out_ready = 1'b1;
            ovf_clr   = 1'b0;
            win_rst   = (m_cnt == int'(WL) - 1) && (i % 3 == 0);
        end

        repeat (60) step(60, 70, 70, 10, 10);

        // Asynchronous reset with results in flight.
        for (int i = 0; i < 40; i++) begin
            if (pend_q.size() > 0 && m_occ > 0) break;
            step(60, 100, 30, 0, 0);
        end
        @(negedge clk);
        #3;
        aclr_n = 1'b0;
        acc    = '0;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        @(negedge clk);
        #1;
        chk("rst_mid_data", int'(out_data), 0);
        chk("rst_mid_ovf", int'(ovf), 0);
        @(negedge clk);
        aclr_n = 1'b1;

        repeat (80) step(70, 75, 60, 5, 5);
        repeat (15) step(10, 0, 100, 0, 0);
        #1;
        chk("final_drain", exp_q.size() + pend_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
